// File: rtl/dnn_result_reader.sv
// Sequencer for one inference run: clears and starts the engine, waits for done,
// sweeps the 10 class scores and returns the signed argmax. Optional watchdog: DNN_READER_TIMEOUT_EN.
module dnn_result_reader #(
    parameter int unsigned DATA_WIDTH     = 5,
    parameter int unsigned NUM_CLASSES    = 10,
    parameter int unsigned IDX_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic                  eng_reset,
    output logic                  eng_start,
    input  logic                  eng_done,
    output logic [IDX_WIDTH-1:0]  out_idx,
    input  logic [DATA_WIDTH-1:0] out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IDX_WIDTH-1:0]  res_digit,
    output logic [DATA_WIDTH-1:0] res_score,
    output logic                  res_error
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {IDLE, CLR, START, WAIT, SWEEP, RESULT} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [IDX_WIDTH-1:0]    best_idx;
    logic [DATA_WIDTH-1:0]   best_score;
    logic                    sweep_last;
    logic                    take_new;
    logic                    timeout_hit;

    assign sweep_last = (out_idx == LAST_IDX);
    // Index 0 always seeds the running best; later indices win only when strictly greater.
    assign take_new   = (out_idx == '0) || ($signed(out) > $signed(best_score));

`ifdef DNN_READER_TIMEOUT_EN
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WCNT_W-1:0] wait_cnt;

    assign timeout_hit = (wait_cnt == WCNT_W'(TIMEOUT_CYCLES - 1));

    // Counts WAIT cycles; zero whenever outside WAIT so each entry starts fresh.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;

    // Watchdog compiled out; the parameter only keeps the interface identical.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid) state_nxt = CLR;
            CLR:     state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (eng_done) begin
                    state_nxt = SWEEP;
                end else if (timeout_hit) begin
                    state_nxt = RESULT;
                end
            end
            SWEEP:   if (sweep_last) state_nxt = RESULT;
            RESULT:  if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they align with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready <= 1'b1;
            eng_reset <= 1'b0;
            eng_start <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            req_ready <= (state_nxt == IDLE);
            eng_reset <= (state_nxt == CLR);
            eng_start <= (state_nxt == START);
            res_valid <= (state_nxt == RESULT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_idx    <= '0;
            best_idx   <= '0;
            best_score <= '0;
            res_digit  <= '0;
            res_score  <= '0;
        end else if (state == SWEEP) begin
            out_idx <= sweep_last ? '0 : out_idx + IDX_WIDTH'(1);
            if (take_new) begin
                best_idx   <= out_idx;
                best_score <= out;
            end
            if (sweep_last) begin
                res_digit <= take_new ? out_idx : best_idx;
                res_score <= take_new ? out : best_score;
            end
        end else if ((state == WAIT) && !eng_done && timeout_hit) begin
            res_digit <= '1;
            res_score <= '0;
        end
    end

`ifdef DNN_READER_TIMEOUT_EN
    // Error flag persists through the handshake and clears on the next accepted request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_error <= 1'b0;
        end else if ((state == IDLE) && req_valid) begin
            res_error <= 1'b0;
        end else if ((state == WAIT) && !eng_done && timeout_hit) begin
            res_error <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_error <= 1'b0;
        end else begin
            res_error <= 1'b0;
        end
    end
`endif

endmodule
